// File: rtl/sram_req_arbiter.sv
// -----------------------------------------------------------------------------
// sram_req_arbiter
//
// Shares one SRAM-like memory port between the fetch-stage instruction
// requester and the mem-stage data requester. Only one transaction is ever
// outstanding on the shared bus. The winning request is latched in IDLE, the
// address phase is driven from ADDR, the response is awaited in DATA, and the
// handshake pulses are routed back to whichever requester owns the transaction.
//
// Build option:
//   SRAM_ARB_RR_EN  defined   : simultaneous requests alternate, starting with
//                               data (last_owner resets to INST).
//                   undefined : fixed priority, data beats instruction.
//
// Ports:
//   clk, rst                  system clock; asynchronous active-high reset
//   inst_req/size/addr        fetch request, held until inst_addr_ok
//   inst_addr_ok/data_ok      one-cycle acceptance / read-data-valid pulses
//   inst_rdata                fetch read data (copy of bus_rdata)
//   data_req/wr/size/addr/wdata  mem-stage request, held until data_addr_ok
//   data_addr_ok/data_ok      one-cycle acceptance / completion pulses
//   data_rdata                load read data (copy of bus_rdata)
//   bus_req/wr/size/addr/wdata   shared-bus request, fields latched at grant
//   bus_addr_ok/data_ok/rdata    shared-bus handshakes and read data
//   busy                      high whenever a transaction is in progress
//
// State table:
//   state | meaning
//   IDLE  | no transaction; arbitrate and latch the winning request
//   ADDR  | bus_req high with latched fields, waiting for bus_addr_ok
//   DATA  | address accepted, waiting for bus_data_ok
// -----------------------------------------------------------------------------
module sram_req_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // instruction requester
    input  logic              inst_req,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    // data requester
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    // shared bus
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,
    // status
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    state_t             state_q, state_d;
    owner_t             owner_q, owner_d;
    logic               bus_wr_q, bus_wr_d;
    logic [1:0]         bus_size_q, bus_size_d;
    logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]  bus_wdata_q, bus_wdata_d;

    logic               grant;
    owner_t             winner;
    logic               addr_ok_hit;
    logic               data_ok_hit;

    // A grant can only happen from IDLE, which is also what enforces the
    // single-outstanding-transaction rule.
    assign grant = (state_q == ST_IDLE) && (inst_req || data_req);

`ifdef SRAM_ARB_RR_EN
    owner_t last_owner_q, last_owner_d;

    // On a tie the requester that did not win last time gets the bus; a lone
    // requester wins regardless of history.
    always_comb begin
        winner = OWN_INST;
        if (inst_req && data_req) begin
            winner = (last_owner_q == OWN_INST) ? OWN_DATA : OWN_INST;
        end else if (data_req) begin
            winner = OWN_DATA;
        end
    end

    always_comb begin
        last_owner_d = last_owner_q;
        if (grant) begin
            last_owner_d = winner;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner_q <= OWN_INST;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    // The mem stage holds the older instruction, so data always wins a tie.
    always_comb begin
        winner = data_req ? OWN_DATA : OWN_INST;
    end
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        bus_wr_d    = bus_wr_q;
        bus_size_d  = bus_size_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        addr_ok_hit = 1'b0;
        data_ok_hit = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    owner_d = winner;
                    state_d = ST_ADDR;
                    if (winner == OWN_DATA) begin
                        bus_wr_d    = data_wr;
                        bus_size_d  = data_size;
                        bus_addr_d  = data_addr;
                        bus_wdata_d = data_wdata;
                    end else begin
                        // fetches are always reads with no write payload
                        bus_wr_d    = 1'b0;
                        bus_size_d  = inst_size;
                        bus_addr_d  = inst_addr;
                        bus_wdata_d = '0;
                    end
                end
            end

            ST_ADDR: begin
                if (bus_addr_ok) begin
                    addr_ok_hit = 1'b1;
                    // the bus may finish the whole transfer in the address cycle
                    if (bus_data_ok) begin
                        data_ok_hit = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d     = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                // a stray bus_addr_ok here belongs to nobody and is ignored
                if (bus_data_ok) begin
                    data_ok_hit = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_INST;
            bus_wr_q    <= 1'b0;
            bus_size_q  <= 2'd0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            bus_wr_q    <= bus_wr_d;
            bus_size_q  <= bus_size_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    // Handshake pulses are combinational from the bus so the owner sees them
    // in the same cycle the bus responds; the non-owner never sees a pulse.
    assign inst_addr_ok = addr_ok_hit && (owner_q == OWN_INST);
    assign data_addr_ok = addr_ok_hit && (owner_q == OWN_DATA);
    assign inst_data_ok = data_ok_hit && (owner_q == OWN_INST);
    assign data_data_ok = data_ok_hit && (owner_q == OWN_DATA);

    assign inst_rdata = bus_rdata;
    assign data_rdata = bus_rdata;

    assign bus_req   = (state_q == ST_ADDR);
    assign bus_wr    = bus_wr_q;
    assign bus_size  = bus_size_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sram_req_arbiter.sv
`timescale 1ns/1ps
module tb_sram_req_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 3000;

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_req;
    logic [1:0]    inst_size;
    logic [AW-1:0] inst_addr;
    logic          inst_addr_ok, inst_data_ok;
    logic [DW-1:0] inst_rdata;
    logic          data_req, data_wr;
    logic [1:0]    data_size;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_addr_ok, data_data_ok;
    logic [DW-1:0] data_rdata;
    logic          bus_req, bus_wr;
    logic [1:0]    bus_size;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_addr_ok, bus_data_ok;
    logic [DW-1:0] bus_rdata;
    logic          busy;

    sram_req_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            own_data;
        bit            wr;
        logic [1:0]    size;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            start;
    } txn_t;

    txn_t          exp_txn_q[$];
    logic [DW-1:0] exp_rdata_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int m_grants = 0;
    int mon_starts = 0;
    bit cmpl_flag = 1'b0;
    bit run_slave = 1'b0;
    bit sl_data_phase = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    // ---------------- reference model: transaction-level arbitration ----------
    bit   m_inflight = 1'b0;
    bit   m_win_data;
    txn_t m_t;
`ifdef SRAM_ARB_RR_EN
    bit   m_last_data = 1'b0;
`endif

    always @(negedge clk) begin
        if (rst) begin
            m_inflight = 1'b0;
`ifdef SRAM_ARB_RR_EN
            m_last_data = 1'b0;
`endif
            exp_txn_q.delete();
            check("rst_ctrl", 64'({busy, bus_req, bus_wr, bus_size, inst_addr_ok,
                                   inst_data_ok, data_addr_ok, data_data_ok}), 64'd0);
            check("rst_bus_addr", 64'(bus_addr), 64'd0);
            check("rst_bus_wdata", 64'(bus_wdata), 64'd0);
        end else begin
            check("busy", 64'(busy), 64'(m_inflight));
            if (!m_inflight && (inst_req || data_req)) begin
`ifdef SRAM_ARB_RR_EN
                if (inst_req && data_req) m_win_data = !m_last_data;
                else                      m_win_data = data_req;
                m_last_data = m_win_data;
`else
                m_win_data = data_req;
`endif
                m_t.own_data = m_win_data;
                m_t.wr       = m_win_data ? data_wr : 1'b0;
                m_t.size     = m_win_data ? data_size : inst_size;
                m_t.addr     = m_win_data ? data_addr : inst_addr;
                m_t.wdata    = m_win_data ? data_wdata : '0;
                m_t.start    = cyc + 1;
                exp_txn_q.push_back(m_t);
                m_inflight = 1'b1;
                m_grants++;
            end else if (m_inflight && cmpl_flag) begin
                m_inflight = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ------------------------------------
    bit            mon_prev_req = 1'b0;
    bit            mon_addr_phase = 1'b0;
    bit            mon_own_data = 1'b0;
    bit            mon_prev_aok = 1'b0;
    bit            exp_iaok, exp_daok;
    txn_t          mon_t;
    logic [DW-1:0] mon_rd;

    always @(negedge clk) begin
        if (rst) begin
            mon_prev_req   = 1'b0;
            mon_addr_phase = 1'b0;
            mon_prev_aok   = 1'b0;
            exp_rdata_q.delete();
        end else begin
            if (bus_req && !mon_prev_req) begin
                mon_starts++;
                if (exp_txn_q.size() == 0) begin
                    check("unexpected_bus_req", 64'(bus_req), 64'd0);
                    mon_addr_phase = 1'b0;
                end else begin
                    mon_t = exp_txn_q.pop_front();
                    check("start_cycle", 64'(cyc), 64'(mon_t.start));
                    mon_own_data   = mon_t.own_data;
                    mon_addr_phase = 1'b1;
                end
            end
            if (bus_req && mon_addr_phase) begin
                check("bus_wr", 64'(bus_wr), 64'(mon_t.wr));
                check("bus_size", 64'(bus_size), 64'(mon_t.size));
                check("bus_addr", 64'(bus_addr), 64'(mon_t.addr));
                check("bus_wdata", 64'(bus_wdata), 64'(mon_t.wdata));
            end
            if (mon_prev_aok) check("bus_req_drop", 64'(bus_req), 64'd0);

            exp_iaok = 1'b0;
            exp_daok = 1'b0;
            if (mon_addr_phase && bus_addr_ok) begin
                exp_iaok = !mon_own_data;
                exp_daok = mon_own_data;
            end
            check("addr_ok", 64'({inst_addr_ok, data_addr_ok}), 64'({exp_iaok, exp_daok}));
            mon_prev_aok = mon_addr_phase && bus_addr_ok;
            if (mon_addr_phase && bus_addr_ok) mon_addr_phase = 1'b0;

            if (cmpl_flag) begin
                mon_rd = (exp_rdata_q.size() != 0) ? exp_rdata_q.pop_front() : '0;
                check("data_ok", 64'({inst_data_ok, data_data_ok}), 64'({!mon_own_data, mon_own_data}));
                check("rdata", 64'(mon_own_data ? data_rdata : inst_rdata), 64'(mon_rd));
            end else begin
                check("no_data_ok", 64'({inst_data_ok, data_data_ok}), 64'd0);
            end
            mon_prev_req = bus_req;
        end
    end

    // ---------------- random bus slave ----------------------------------------
    initial begin
        forever begin
            @(posedge clk); #1;
            if (run_slave) begin
                bus_addr_ok = 1'b0;
                bus_data_ok = 1'b0;
                cmpl_flag   = 1'b0;
                bus_rdata   = $urandom;
                if (!sl_data_phase) begin
                    if (bus_req && $urandom_range(0, 1) == 1) begin
                        bus_addr_ok = 1'b1;
                        if ($urandom_range(0, 3) == 0) begin
                            bus_data_ok = 1'b1;
                            cmpl_flag   = 1'b1;
                            exp_rdata_q.push_back(bus_rdata);
                        end else begin
                            sl_data_phase = 1'b1;
                        end
                    end
                end else begin
                    if ($urandom_range(0, 2) == 0) begin
                        bus_data_ok   = 1'b1;
                        cmpl_flag     = 1'b1;
                        exp_rdata_q.push_back(bus_rdata);
                        sl_data_phase = 1'b0;
                    end else if ($urandom_range(0, 3) == 0) begin
                        bus_addr_ok = 1'b1;   // stray accept during data phase
                    end
                end
            end
        end
    end

    // ---------------- directed helpers ----------------------------------------
    task automatic tick();
        @(posedge clk); #1;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        cmpl_flag   = 1'b0;
        bus_rdata   = $urandom;
    endtask

    task automatic complete(input logic [DW-1:0] rd);
        bus_data_ok = 1'b1;
        bus_rdata   = rd;
        cmpl_flag   = 1'b1;
        exp_rdata_q.push_back(rd);
    endtask

    // ---------------- random requesters ---------------------------------------
    task automatic inst_agent(input int n);
        for (int k = 0; k < n; k++) begin
            int w;
            repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
            inst_req  = 1'b1;
            inst_size = 2'($urandom_range(0, 2));
            inst_addr = $urandom;
            w = 0;
            do begin @(negedge clk); w++; end while (!inst_addr_ok && w < TMO);
            if (!inst_addr_ok) check("inst_ack_timeout", 64'(inst_addr_ok), 64'd1);
            @(posedge clk); #1;
            inst_req = 1'b0;
        end
    endtask

    task automatic data_agent(input int n);
        for (int k = 0; k < n; k++) begin
            int w;
            repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
            data_req   = 1'b1;
            data_wr    = 1'($urandom_range(0, 1));
            data_size  = 2'($urandom_range(0, 2));
            data_addr  = $urandom;
            data_wdata = $urandom;
            w = 0;
            do begin @(negedge clk); w++; end while (!data_addr_ok && w < TMO);
            if (!data_addr_ok) check("data_ack_timeout", 64'(data_addr_ok), 64'd1);
            @(posedge clk); #1;
            data_req = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit got_i;
        int w;
        rst = 1'b1;
        inst_req = 1'b0; inst_size = 2'd0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = '0; data_wdata = '0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
        repeat (2) @(negedge clk);
        tick(); rst = 1'b0;
        tick();

        // fetch: accept in cycle 2, data in cycle 4
        tick(); inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'hBFC0_0000;
        tick();
        tick(); bus_addr_ok = 1'b1;
        tick(); inst_req = 1'b0;
        tick(); complete(32'h3C1D_0000);
        tick();

        // store with address phase held for two cycles
        tick(); data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
                data_addr = 32'h8000_1000; data_wdata = 32'hDEAD_BEEF;
        tick();
        tick();
        tick(); bus_addr_ok = 1'b1;
        tick(); data_req = 1'b0;
        tick();
        tick(); complete($urandom);
        tick();

        // tie, accept+done in one cycle, then a second tie straight away
        tick(); inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'h0040_0000;
                data_req = 1'b1; data_wr = 1'b0; data_size = 2'd1; data_addr = 32'h8000_2000;
        tick(); bus_addr_ok = 1'b1; complete($urandom);
        tick(); data_addr = 32'h8000_2004; data_size = 2'd2;
        tick(); bus_addr_ok = 1'b1; complete($urandom);
        @(negedge clk); got_i = inst_addr_ok;
        tick(); if (got_i) inst_req = 1'b0; else data_req = 1'b0;
        tick(); bus_addr_ok = 1'b1;
        tick(); inst_req = 1'b0; data_req = 1'b0;
        tick(); complete($urandom);
        tick();

        // reset while in DATA, then a stale bus_data_ok
        tick(); data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_3000;
        tick();
        tick(); bus_addr_ok = 1'b1;
        tick(); data_req = 1'b0;
        tick(); rst = 1'b1; #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_bus_ctrl", 64'({bus_req, bus_wr, bus_size}), 64'd0);
        check("arst_bus_addr", 64'(bus_addr), 64'd0);
        tick(); rst = 1'b0;
        tick(); bus_data_ok = 1'b1;
        tick();
        tick();

        // request withdrawn the cycle after grant still completes
        tick(); data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
                data_addr = 32'h8000_4001; data_wdata = 32'h0000_00A5;
        tick(); data_req = 1'b0;
        tick(); bus_addr_ok = 1'b1;
        tick(); complete($urandom);
        tick();

        // randomized traffic
        run_slave = 1'b1;
        fork
            inst_agent(40);
            data_agent(60);
        join
        w = 0;
        while ((busy || exp_txn_q.size() != 0) && w < 500) begin @(negedge clk); w++; end
        @(negedge clk); run_slave = 1'b0;
        tick();
        tick();

        check("end_txn_q_empty", 64'(exp_txn_q.size()), 64'd0);
        check("end_rdata_q_empty", 64'(exp_rdata_q.size()), 64'd0);
        check("end_idle", 64'(busy), 64'd0);
        check("starts_vs_grants", 64'(mon_starts), 64'(m_grants));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
